// File: rtl/ac_ctrl_pkg.sv
// Shared types and width helpers for the multi-zone AC controller.
package ac_ctrl_pkg;

   typedef enum logic [1:0] {
      ZONE_OFF  = 2'b00,
      ZONE_RUN  = 2'b01,
      ZONE_HOLD = 2'b10
   } zone_state_e;

   localparam int ZONE_STATE_W = 2;

   // Bits needed to hold the values 0..n inclusive.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ac_sensor_debounce.sv
// One raw sensor bit: 2-FF synchroniser followed by a stable-count debouncer.
module ac_sensor_debounce
   import ac_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic db_o
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);

   logic          sync1_q;
   logic          sync2_q;
   logic          db_q;
   logic          db_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Everything resets to "open" so a zone cannot start before sensors settle closed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         db_q    <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
      end
   end

   // The edge that would bring the count to DEBOUNCE_CYCLES takes the new value.
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync2_q != db_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_d  = sync2_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   assign db_o = db_q;

endmodule

// File: rtl/ac_zone_controller.sv
// Multi-zone AC controller: debounced sensors, per-zone OFF/RUN/HOLD FSM and a shared run budget.
module ac_zone_controller
   import ac_ctrl_pkg::*;
#(
   parameter int NUM_ZONES       = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int MIN_OFF_CYCLES  = 1000,
   parameter int MAX_ACTIVE      = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_ZONES-1:0]                 door_open,
   input  logic [NUM_ZONES-1:0]                 window_open,
   input  logic [NUM_ZONES-1:0]                 zone_en,
   output logic [NUM_ZONES-1:0]                 ac_on,
   output logic [ZONE_STATE_W*NUM_ZONES-1:0]    zone_state,
   output logic [cnt_width(NUM_ZONES)-1:0]      active_count,
   output logic [NUM_ZONES-1:0]                 lockout
);

   localparam int AW = cnt_width(NUM_ZONES);
   localparam int TW = cnt_width(MIN_OFF_CYCLES);

   logic [NUM_ZONES-1:0] door_db;
   logic [NUM_ZONES-1:0] window_db;
   logic [NUM_ZONES-1:0] req;
   logic [NUM_ZONES-1:0] is_off;
   logic [NUM_ZONES-1:0] is_run;
   logic [NUM_ZONES-1:0] is_hold;
   logic [NUM_ZONES-1:0] grant;
   logic [AW-1:0]        run_cnt;
   logic [AW-1:0]        slots;
   logic [AW-1:0]        given;

   always_comb begin
      run_cnt = '0;
      for (int i = 0; i < NUM_ZONES; i++) begin
         run_cnt = run_cnt + AW'(is_run[i]);
      end
   end

   // Slots come from registered RUN states, so a zone leaving RUN frees its slot a cycle later.
   always_comb begin
      slots = (run_cnt >= AW'(MAX_ACTIVE)) ? '0 : (AW'(MAX_ACTIVE) - run_cnt);
      given = '0;
      grant = '0;
      for (int i = 0; i < NUM_ZONES; i++) begin
         if (is_off[i] && req[i] && (given < slots)) begin
            grant[i] = 1'b1;
            given    = given + AW'(1);
         end
      end
   end

   assign active_count = run_cnt;

   for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
      zone_state_e   state_q;
      zone_state_e   state_d;
      logic [TW-1:0] timer_q;
      logic [TW-1:0] timer_d;

      ac_sensor_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_door_db (
         .clk   (clk),
         .reset (reset),
         .raw_i (door_open[z]),
         .db_o  (door_db[z])
      );

      ac_sensor_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_window_db (
         .clk   (clk),
         .reset (reset),
         .raw_i (window_open[z]),
         .db_o  (window_db[z])
      );

      assign req[z] = zone_en[z] & ~door_db[z] & ~window_db[z];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q <= ZONE_OFF;
            timer_q <= '0;
         end else begin
            state_q <= state_d;
            timer_q <= timer_d;
         end
      end

      // HOLD lasts MIN_OFF_CYCLES cycles: load N-1, leave on the cycle the timer reads 0.
      always_comb begin
         state_d = state_q;
         timer_d = timer_q;
         case (state_q)
            ZONE_OFF: begin
               timer_d = '0;
               if (grant[z]) begin
                  state_d = ZONE_RUN;
               end
            end
            ZONE_RUN: begin
               if (!req[z]) begin
                  state_d = ZONE_HOLD;
                  timer_d = TW'(MIN_OFF_CYCLES - 1);
               end
            end
            ZONE_HOLD: begin
               if (timer_q == '0) begin
                  state_d = ZONE_OFF;
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
            default: begin
               state_d = ZONE_OFF;
               timer_d = '0;
            end
         endcase
      end

      assign is_off[z]  = (state_q == ZONE_OFF);
      assign is_run[z]  = (state_q == ZONE_RUN);
      assign is_hold[z] = (state_q == ZONE_HOLD);

      assign zone_state[ZONE_STATE_W*z +: ZONE_STATE_W] = state_q;
      assign ac_on[z]   = is_run[z];
      assign lockout[z] = is_hold[z];
   end

endmodule

// File: doc/ac_zone_controller.md
Name: ac_zone_controller

Overview:
- Multi-zone successor to the single-room door/window AC controller.
- Each of NUM_ZONES zones has door and window sensors, a debouncer and a 3-state FSM (OFF/RUN/HOLD) with a compressor minimum-off lockout.
- A global budget limits how many zones run at once; zones are granted in fixed priority, lowest index first.
- Sits between the raw building sensor inputs and the per-zone compressor relay drivers.

Parameters:
- NUM_ZONES, 4, number of independent zones (1..16)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a debounced sensor changes (>=1)
- MIN_OFF_CYCLES, 1000, cycles a zone stays in HOLD after leaving RUN (>=1)
- MAX_ACTIVE, 2, maximum zones in RUN at once (1..NUM_ZONES)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- door_open  in  NUM_ZONES  raw door sensor per zone, 1=open, asynchronous to clk
- window_open  in  NUM_ZONES  raw window sensor per zone, 1=open, asynchronous to clk
- zone_en  in  NUM_ZONES  per-zone demand/enable from the thermostat, synchronous
- ac_on  out  NUM_ZONES  compressor relay per zone, 1 exactly when that zone is in RUN
- zone_state  out  2*NUM_ZONES  per-zone state code, zone i at bits [2i+1:2i]
- active_count  out  $clog2(NUM_ZONES+1)  number of zones currently in RUN
- lockout  out  NUM_ZONES  1 while the zone is in HOLD

Behaviour:
- Reset:
  - Clock is clk; reset is asynchronous, active-high.
  - All zones go to OFF; ac_on=0, lockout=0, zone_state=0, active_count=0.
  - Synchronisers and debounced values reset to 1 (open), so no zone can request RUN until sensors are debounced closed.
  - Counters clear to 0.
  - Reset asserted mid-RUN or mid-HOLD drops ac_on immediately, asynchronously; no HOLD is served after reset.
- Synchronisation:
  - Each raw sensor bit passes through a 2-FF synchroniser.
- Debounce:
  - Each debounced bit keeps a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - When the synchronised value equals the debounced value, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced value takes the synchronised value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES has no effect.
  - Latency from a held raw change to the debounced change: 2+DEBOUNCE_CYCLES clocks.
- Run request per zone:
  - req[i] = zone_en[i] & ~door_db[i] & ~window_db[i].
- FSM per zone (encoding OFF=2'b00, RUN=2'b01, HOLD=2'b10; 2'b11 returns to OFF):
  - OFF -> RUN when req[i] is 1 and the zone holds a grant.
  - RUN -> HOLD when req[i] is 0. On entry to HOLD the off-timer loads MIN_OFF_CYCLES-1.
  - HOLD decrements the timer each cycle. HOLD -> OFF on the cycle the timer is 0, giving exactly MIN_OFF_CYCLES cycles in HOLD.
  - In HOLD, req is ignored; a zone never goes HOLD -> RUN directly.
  - ac_on rises one clock after req rises (state update); it falls one clock after req falls.
- Grant / budget:
  - slots = MAX_ACTIVE - (number of zones registered in RUN this cycle).
  - Among zones in OFF with req=1, grants go to the lowest indices first, up to slots.
  - A zone leaving RUN in the same cycle does not free its slot until the next cycle.
  - Ungranted zones stay in OFF and retry every cycle.
  - active_count never exceeds MAX_ACTIVE.
- Outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Timer width: $clog2(MIN_OFF_CYCLES+1). Timers never wrap: the decrement saturates at 0.

Decomposition:
- Shared package ac_ctrl_pkg:
  - zone state typedef/constants ZONE_OFF, ZONE_RUN, ZONE_HOLD
  - width helper constants for the counter widths
- Sub-module ac_sensor_debounce: one bit, with 2-FF sync and stable counter, parameter DEBOUNCE_CYCLES.
  - Instantiated 2*NUM_ZONES times.
- FSMs, timers and the grant logic stay in the top level, using a generate loop.

Test Plan (NUM_ZONES=4, DEBOUNCE_CYCLES=4, MIN_OFF_CYCLES=8, MAX_ACTIVE=2):
- Reset release with all sensors 0 and zone_en=4'b0001 -> ac_on[0] rises 7 clocks after reset release (2 sync + 4 debounce + 1 FSM); active_count=1.
- Zone 0 running, door_open[0] pulse high for 3 cycles -> ac_on[0] stays 1 throughout; zone_state[1:0] stays RUN.
- Zone 0 running, door_open[0]=1 held -> ac_on[0]=0 after 7 clocks, lockout[0]=1 for exactly 8 cycles. Door closed again during HOLD -> RUN re-entered only after HOLD ends.
- All sensors closed, zone_en=4'b1111 in one cycle -> zones 0,1 RUN, zones 2,3 OFF, active_count=2. Then zone_en[0]=0 -> zone 2 enters RUN 1 clock after zone 0 enters HOLD.
- Reset asserted mid-HOLD and mid-RUN -> all ac_on=0 and lockout=0 immediately; after release, no RUN before 7 clocks.
- Force an illegal state 2'b11 via the bench -> OFF on the next clock, ac_on=0.
